// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-line controller.
//   - sd_cmd_state_e : controller FSM encoding (IDLE, SEND, WAIT_RESP, RECV, DONE)
//   - FRAME_W        : command/response frame width, fixed at 48 bits
//   - CRC7_POLY      : CRC7 polynomial x^7 + x^3 + 1 (low 7 bits, x^7 implied)
//   - START_BIT / TX_BIT / END_BIT : fixed framing bits of a host command
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_RECV      = 3'd3,
    ST_DONE      = 3'd4
  } sd_cmd_state_e;

  localparam int         FRAME_W   = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic       START_BIT = 1'b0;
  localparam logic       TX_BIT    = 1'b1;
  localparam logic       END_BIT   = 1'b1;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1, initial value 0) over a 40-bit word,
// processed MSB first -- the first 40 bits of an SD CMD-line frame.
// Ports:
//   data : 40-bit input (frame bits [47:8])
//   crc  : 7-bit CRC result
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  logic [6:0] acc;
  logic       fb;

  // Bit-serial LFSR unrolled across the 40 data bits.
  always_comb begin
    acc = 7'h00;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ acc[6];
      acc = {acc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    crc = acc;
  end

endmodule

// File: rtl/sd_cmd_controller.sv
// SD CMD-line transaction sequencer (card-clock domain).
// Latches a command on start, builds the 48-bit frame with CRC7, hands it to
// the parallel-to-serial block, then optionally hunts for and deserializes
// the card's 48-bit response, flagging timeout / end-bit / index errors.
//
// Optional feature: define SD_CMD_RESP_CRC_CHECK_EN to recompute CRC7 over
// the received frame and report mismatches on crc_err (otherwise tied 0).
//
// Ports:
//   CLK, RESET            : card clock, async active-high reset
//   start                 : command request, honoured only in IDLE
//   cmd_index, cmd_arg    : command fields, latched on accepted start
//   resp_expected         : 1 = a 48-bit response follows the command
//   ser_frame, ser_start  : frame and send-level to the serializer
//   ser_finished          : serializer completion pulse
//   cmd_in                : CMD line from card (idles high)
//   busy, done            : activity level and one-cycle completion pulse
//   resp_index, resp_arg  : fields of the received response
//   timeout_err, end_err, index_err, crc_err : response error flags
//   state_dbg             : current FSM state for observation
//
// Serializer handshake: ser_start is a level that rises on entry to SEND and
// stays high with ser_frame stable until ser_finished is seen high on a clock
// edge; ser_start is low from the following cycle. ser_finished is only
// looked at while in SEND.
module sd_cmd_controller
  import sd_cmd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64
)
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [5:0]         cmd_index,
  input  logic [31:0]        cmd_arg,
  input  logic               resp_expected,
  output logic [FRAME_W-1:0] ser_frame,
  output logic               ser_start,
  input  logic               ser_finished,
  input  logic               cmd_in,
  output logic               busy,
  output logic               done,
  output logic [5:0]         resp_index,
  output logic [31:0]        resp_arg,
  output logic               timeout_err,
  output logic               end_err,
  output logic               index_err,
  output logic               crc_err,
  output sd_cmd_state_e      state_dbg
);

  localparam int               CNT_W   = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RESP_TIMEOUT - 1);

  sd_cmd_state_e      state, state_next;
  logic [5:0]         idx_q;
  logic               resp_exp_q;
  logic               got_resp_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [5:0]         bit_cnt;
  logic [FRAME_W-1:0] resp_sr;
  logic [6:0]         tx_crc;

  // CRC is taken from the live inputs so the frame can be registered on the
  // same edge that accepts start.
  sd_crc7 u_tx_crc (
    .data ({START_BIT, TX_BIT, cmd_index, cmd_arg}),
    .crc  (tx_crc)
  );

  assign busy      = (state != ST_IDLE);
  assign ser_start = (state == ST_SEND);
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_SEND;
      ST_SEND:      if (ser_finished) state_next = resp_exp_q ? ST_WAIT_RESP : ST_DONE;
      // Start bit is tested first so it wins over a same-cycle timeout.
      ST_WAIT_RESP: if (!cmd_in) state_next = ST_RECV;
                    else if (wait_cnt == TO_LAST) state_next = ST_DONE;
      ST_RECV:      if (bit_cnt == 6'd0) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // done is registered off the DONE state, so it (and the result fields
  // captured in DONE) appear together one cycle after DONE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ser_frame   <= '0;
      done        <= 1'b0;
      idx_q       <= '0;
      resp_exp_q  <= 1'b0;
      got_resp_q  <= 1'b0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      resp_sr     <= '0;
      resp_index  <= '0;
      resp_arg    <= '0;
      timeout_err <= 1'b0;
      end_err     <= 1'b0;
      index_err   <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx_q       <= cmd_index;
            resp_exp_q  <= resp_expected;
            ser_frame   <= {START_BIT, TX_BIT, cmd_index, cmd_arg, tx_crc, END_BIT};
            got_resp_q  <= 1'b0;
            wait_cnt    <= '0;
            resp_index  <= '0;
            resp_arg    <= '0;
            timeout_err <= 1'b0;
            end_err     <= 1'b0;
            index_err   <= 1'b0;
          end
        end
        ST_WAIT_RESP: begin
          if (!cmd_in) begin
            // The start bit itself becomes frame bit 47 after 47 more shifts.
            got_resp_q <= 1'b1;
            resp_sr    <= '0;
            bit_cnt    <= 6'd46;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          resp_sr <= {resp_sr[FRAME_W-2:0], cmd_in};
          bit_cnt <= bit_cnt - 1'b1;
        end
        ST_DONE: begin
          if (got_resp_q) begin
            resp_index <= resp_sr[45:40];
            resp_arg   <= resp_sr[39:8];
            end_err    <= ~resp_sr[0];
            index_err  <= (resp_sr[45:40] != idx_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;

  sd_crc7 u_rx_crc (
    .data (resp_sr[47:8]),
    .crc  (rx_crc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      crc_err <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      crc_err <= 1'b0;
    end else if (state == ST_DONE && got_resp_q) begin
      crc_err <= (rx_crc != resp_sr[7:1]);
    end
  end
`else
  // Framing and CRC bits of the response are not inspected in this build.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{resp_sr[47:46], resp_sr[7:1]};
  assign crc_err          = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_controller.sv
module tb_sd_cmd_controller;
  import sd_cmd_pkg::*;

  localparam int RESP_TIMEOUT = 64;
  localparam int RES_W        = 42;  // {resp_index, resp_arg, timeout, end, index, crc}

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    cmd_index = '0;
  logic [31:0]   cmd_arg = '0;
  logic          resp_expected = 1'b0;
  logic [47:0]   ser_frame;
  logic          ser_start;
  logic          ser_finished = 1'b0;
  logic          cmd_in = 1'b1;
  logic          busy, done;
  logic [5:0]    resp_index;
  logic [31:0]   resp_arg;
  logic          timeout_err, end_err, index_err, crc_err;
  sd_cmd_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0]      exp_frame_q[$];
  logic [RES_W-1:0] exp_q[$];

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  sd_cmd_controller #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_expected(resp_expected), .ser_frame(ser_frame),
    .ser_start(ser_start), .ser_finished(ser_finished), .cmd_in(cmd_in),
    .busy(busy), .done(done), .resp_index(resp_index), .resp_arg(resp_arg),
    .timeout_err(timeout_err), .end_err(end_err), .index_err(index_err),
    .crc_err(crc_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // CRC7 as polynomial long division of data * x^7 by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_model(input logic [39:0] data);
    logic [46:0] m;
    m = {data, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg, crc7_model({2'b00, idx, arg}), 1'b1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic re,
                       input logic [47:0] exp_frame);
    logic [47:0] ef;
    @(negedge CLK);
    start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_expected = re;
    exp_frame_q.push_back(exp_frame);
    @(negedge CLK);
    // Scramble the inputs: the DUT must be working from its latched copy.
    start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom; resp_expected = 1'($urandom);
    n_checks++;
    if ({busy, ser_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL send_entry: busy/ser_start=%b required 11", {busy, ser_start});
    end
    ef = exp_frame_q.pop_front();
    n_checks++;
    if (ser_frame !== ef) begin
      n_fail++;
      $display("FAIL ser_frame: got %h required %h", ser_frame, ef);
    end
  endtask

  // Serializer model: finishes after 'cycles' cycles; returns at the first
  // cycle after the ser_finished pulse was sampled.
  task automatic serialize(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      n_checks++;
      if (ser_start !== 1'b1) begin
        n_fail++;
        $display("FAIL ser_start_hold: got %b required 1", ser_start);
      end
    end
    ser_finished = 1'b1;
    @(negedge CLK);
    ser_finished = 1'b0;
    n_checks++;
    if (ser_start !== 1'b0) begin
      n_fail++;
      $display("FAIL ser_start_drop: got %b required 0", ser_start);
    end
  endtask

  // Card model: idles high for 'idle' cycles, then sends word MSB first.
  task automatic send_response(input logic [47:0] word, input int idle, input int nbits);
    for (int i = 0; i < idle; i++) begin
      cmd_in = 1'b1;
      @(negedge CLK);
    end
    for (int b = 47; b > 47 - nbits; b--) begin
      cmd_in = word[b];
      @(negedge CLK);
    end
    cmd_in = 1'b1;
  endtask

  // Scoreboard pop: waits (bounded) for done, then compares the result record.
  task automatic wait_done(input string name);
    logic             seen;
    logic [RES_W-1:0] exp, got;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done=%b required 1 within 300 cycles", name, done);
    end else begin
      got = {resp_index, resp_arg, timeout_err, end_err, index_err, crc_err};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_result: got idx=%h arg=%h to/end/idx/crc=%b required idx=%h arg=%h to/end/idx/crc=%b",
                 name, got[41:36], got[35:4], got[3:0], exp[41:36], exp[35:4], exp[3:0]);
      end
      @(negedge CLK);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_width: done=%b required 0 one cycle later", name, done);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge CLK);
    n_checks++;
    if ({ser_frame, ser_start, busy, done, resp_index, resp_arg, timeout_err, end_err,
         index_err, crc_err} !== '0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: frame=%h ser_start=%b busy=%b done=%b state=%0d required all 0",
               ser_frame, ser_start, busy, done, state_dbg);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_cmd0();
    logic [RES_W-1:0] exp, got;
    issue(6'd0, 32'd0, 1'b0, 48'h40_0000_0000_95);
    exp_q.push_back('0);
    serialize(3);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd0_latency_early: done=%b required 0 in ser_start drop cycle", done);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd0_latency: done=%b required 1 one cycle after ser_start drop", done);
    end
    exp = exp_q.pop_front();
    got = {resp_index, resp_arg, timeout_err, end_err, index_err, crc_err};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cmd0_result: got %h required %h", got, exp);
    end
    @(negedge CLK);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL cmd0_idle: done/busy=%b required 00", {done, busy});
    end
  endtask

  task automatic test_cmd8();
    issue(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87);
    exp_q.push_back({6'd8, 32'h1AA, 4'b0000});
    serialize(5);
    send_response(48'h08_0000_01AA_13, 10, 48);
    wait_done("cmd8");
  endtask

  task automatic test_timeout();
    issue(6'd17, 32'd0, 1'b1, 48'h51_0000_0000_55);
    exp_q.push_back({6'd0, 32'd0, 4'b1000});
    serialize(2);
    // Now in the first WAIT_RESP cycle; cmd_in stays high.
    repeat (RESP_TIMEOUT - 1) @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: timeout_err=%b required 0 after %0d cycles", timeout_err, RESP_TIMEOUT - 1);
    end
    @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_exact: timeout_err=%b required 1 after %0d cycles", timeout_err, RESP_TIMEOUT);
    end
    wait_done("cmd17_timeout");
  endtask

  task automatic test_resp_errors();
    logic [47:0] w;
    w = {2'b00, 6'd5, 32'h1AA, crc7_model({2'b00, 6'd5, 32'h1AA}) ^ 7'h01, 1'b0};
    issue(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87);
    exp_q.push_back({6'd5, 32'h1AA, 1'b0, 1'b1, 1'b1, CRC_ON});
    serialize(4);
    send_response(w, 3, 48);
    wait_done("resp_errors");
  endtask

  task automatic test_start_during_send();
    logic [47:0] f;
    f = cmd_frame(6'd55, 32'hDEAD_BEEF);
    issue(6'd55, 32'hDEAD_BEEF, 1'b0, f);
    exp_q.push_back('0);
    @(negedge CLK);
    start = 1'b1; cmd_index = 6'h3F; cmd_arg = 32'hFFFF_FFFF;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ser_frame !== f || ser_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_send: frame=%h ser_start=%b required %h 1", ser_frame, ser_start, f);
    end
    serialize(2);
    wait_done("start_in_send");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_not_queued: busy=%b required 0", busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_in_recv();
    logic saw_done;
    issue(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87);
    serialize(2);
    send_response(48'h08_0000_01AA_13, 2, 12);
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({ser_frame, ser_start, busy, done, resp_index, resp_arg, timeout_err, end_err,
         index_err, crc_err} !== '0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_in_recv: frame=%h ser_start=%b busy=%b state=%0d required all 0",
               ser_frame, ser_start, busy, state_dbg);
    end
    @(negedge CLK);
    RESET = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge CLK);
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulse seen=%b required 0", saw_done);
    end
    test_cmd0();
  endtask

  task automatic test_random();
    logic [5:0]  idx, ridx;
    logic [31:0] arg, rarg;
    for (int k = 0; k < 4; k++) begin
      idx  = 6'($urandom_range(0, 63));
      arg  = $urandom;
      rarg = $urandom;
      ridx = (k == 3) ? ~idx : idx;
      issue(idx, arg, 1'b1, cmd_frame(idx, arg));
      exp_q.push_back({ridx, rarg, 1'b0, 1'b0, (k == 3), 1'b0});
      serialize($urandom_range(1, 6));
      send_response(resp_frame(ridx, rarg), $urandom_range(0, 20), 48);
      wait_done("random");
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_resp_errors();
    test_start_during_send();
    test_reset_in_recv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
